ex_stage: RTL and testbench

//  Execute stage directly downstream of the ID/EX pipeline register. Selects operand B, computes

---
 rtl/ex_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_ex_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: operand-B select, single-cycle ALU and a sequential unsigned
// mul/div unit (shift-add / restoring), registered into the EX/MEM boundary.
module ex_stage #(
    parameter int DATA_WIDTH       = 32,
    parameter int ALU_CONTROL_CODE = 4,
    parameter int RD_WIDTH         = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_i,
    input  logic [DATA_WIDTH-1:0]       rd1_data_i,
    input  logic [DATA_WIDTH-1:0]       rd2_data_i,
    input  logic [DATA_WIDTH-1:0]       imm_i,
    input  logic                        alu_src_i,
    input  logic [ALU_CONTROL_CODE-1:0] alu_control_i,
    input  logic [3:0]                  control_flow_i,
    input  logic [RD_WIDTH-1:0]         rd_i,
    input  logic                        flush_i,
    output logic                        valid_o,
    output logic [DATA_WIDTH-1:0]       alu_result_o,
    output logic [DATA_WIDTH-1:0]       store_data_o,
    output logic [3:0]                  control_flow_o,
    output logic [RD_WIDTH-1:0]         rd_o,
    output logic                        stall_o
);

    localparam int SHW = $clog2(DATA_WIDTH);

    localparam logic [ALU_CONTROL_CODE-1:0] OP_ADD  = 'd0;
    localparam logic [ALU_CONTROL_CODE-1:0] OP_SUB  = 'd1;
    localparam logic [ALU_CONTROL_CODE-1:0] OP_AND  = 'd2;
    localparam logic [ALU_CONTROL_CODE-1:0] OP_OR   = 'd3;
    localparam logic [ALU_CONTROL_CODE-1:0] OP_XOR  = 'd4;
    localparam logic [ALU_CONTROL_CODE-1:0] OP_SLL  = 'd5;
    localparam logic [ALU_CONTROL_CODE-1:0] OP_SRL  = 'd6;
    localparam logic [ALU_CONTROL_CODE-1:0] OP_SRA  = 'd7;
    localparam logic [ALU_CONTROL_CODE-1:0] OP_SLT  = 'd8;
    localparam logic [ALU_CONTROL_CODE-1:0] OP_SLTU = 'd9;
    localparam logic [ALU_CONTROL_CODE-1:0] OP_MUL  = 'd10;
    localparam logic [ALU_CONTROL_CODE-1:0] OP_DIVU = 'd11;
    localparam logic [ALU_CONTROL_CODE-1:0] OP_REMU = 'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t                      state_reg, state_next;
    logic [SHW-1:0]              counter_reg, counter_next;
    logic [ALU_CONTROL_CODE-1:0] op_reg, op_next;
    logic [DATA_WIDTH-1:0]       a_reg, a_next;
    logic [DATA_WIDTH-1:0]       b_reg, b_next;
    logic [DATA_WIDTH-1:0]       acc_reg, acc_next;
    logic [RD_WIDTH-1:0]         rd_lat_reg, rd_lat_next;
    logic [3:0]                  cf_lat_reg, cf_lat_next;
    logic [DATA_WIDTH-1:0]       store_lat_reg, store_lat_next;

    logic                        valid_next;
    logic [DATA_WIDTH-1:0]       result_next;
    logic [DATA_WIDTH-1:0]       store_next;
    logic [3:0]                  cf_next;
    logic [RD_WIDTH-1:0]         rd_next;

    logic [DATA_WIDTH-1:0]       b_operand;
    logic [SHW-1:0]              shamt;
    logic                        is_muldiv;
    logic [DATA_WIDTH-1:0]       alu_out;

    assign b_operand = alu_src_i ? imm_i : rd2_data_i;
    assign shamt     = b_operand[SHW-1:0];
    assign is_muldiv = (alu_control_i == OP_MUL) || (alu_control_i == OP_DIVU) ||
                       (alu_control_i == OP_REMU);

    always_comb begin
        alu_out = '0;
        case (alu_control_i)
            OP_ADD:  alu_out = rd1_data_i + b_operand;
            OP_SUB:  alu_out = rd1_data_i - b_operand;
            OP_AND:  alu_out = rd1_data_i & b_operand;
            OP_OR:   alu_out = rd1_data_i | b_operand;
            OP_XOR:  alu_out = rd1_data_i ^ b_operand;
            OP_SLL:  alu_out = rd1_data_i << shamt;
            OP_SRL:  alu_out = rd1_data_i >> shamt;
            OP_SRA:  alu_out = $unsigned($signed(rd1_data_i) >>> shamt);
            OP_SLT:  alu_out = {{(DATA_WIDTH-1){1'b0}}, ($signed(rd1_data_i) < $signed(b_operand))};
            OP_SLTU: alu_out = {{(DATA_WIDTH-1){1'b0}}, (rd1_data_i < b_operand)};
            default: alu_out = '0;
        endcase
    end

    // One iteration of each algorithm. Multiply: a = shifting multiplicand,
    // b = shifting multiplier, acc = partial product. Divide: a = dividend
    // shifting out / quotient shifting in, b = divisor, acc = remainder.
    logic [DATA_WIDTH-1:0] mul_acc, mul_a, mul_b;
    logic [DATA_WIDTH:0]   div_shifted, div_diff;
    logic [DATA_WIDTH-1:0] div_acc, div_a;

    always_comb begin
        mul_acc     = b_reg[0] ? (acc_reg + a_reg) : acc_reg;
        mul_a       = a_reg << 1;
        mul_b       = b_reg >> 1;
        div_shifted = {acc_reg, a_reg[DATA_WIDTH-1]};
        div_diff    = div_shifted - {1'b0, b_reg};
        // A zero divisor never borrows, so the quotient fills with ones and
        // the remainder ends up equal to the dividend.
        div_acc     = div_diff[DATA_WIDTH] ? div_shifted[DATA_WIDTH-1:0] : div_diff[DATA_WIDTH-1:0];
        div_a       = {a_reg[DATA_WIDTH-2:0], ~div_diff[DATA_WIDTH]};
    end

    always_comb begin
        state_next     = state_reg;
        counter_next   = counter_reg;
        op_next        = op_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        acc_next       = acc_reg;
        rd_lat_next    = rd_lat_reg;
        cf_lat_next    = cf_lat_reg;
        store_lat_next = store_lat_reg;
        valid_next     = valid_o;
        result_next    = alu_result_o;
        store_next     = store_data_o;
        cf_next        = control_flow_o;
        rd_next        = rd_o;
        stall_o        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                stall_o    = valid_i & is_muldiv;
                valid_next = valid_i & ~is_muldiv;
                cf_next    = (valid_i && !is_muldiv) ? control_flow_i : 4'd0;
                if (valid_i && is_muldiv) begin
                    state_next     = ST_BUSY;
                    counter_next   = SHW'(DATA_WIDTH - 1);
                    op_next        = alu_control_i;
                    a_next         = rd1_data_i;
                    b_next         = b_operand;
                    acc_next       = '0;
                    rd_lat_next    = rd_i;
                    cf_lat_next    = control_flow_i;
                    store_lat_next = rd2_data_i;
                end else if (valid_i) begin
                    result_next = alu_out;
                    store_next  = rd2_data_i;
                    rd_next     = rd_i;
                end
            end
            ST_BUSY: begin
                stall_o    = 1'b1;
                valid_next = 1'b0;
                cf_next    = 4'd0;
                if (op_reg == OP_MUL) begin
                    acc_next = mul_acc;
                    a_next   = mul_a;
                    b_next   = mul_b;
                end else begin
                    acc_next = div_acc;
                    a_next   = div_a;
                end
                if (counter_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
                    counter_next = counter_reg - 1'b1;
                end
            end
            ST_DONE: begin
                valid_next  = 1'b1;
                result_next = (op_reg == OP_DIVU) ? a_reg : acc_reg;
                store_next  = store_lat_reg;
                rd_next     = rd_lat_reg;
                cf_next     = cf_lat_reg;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Flush kills whatever is in EX, including an instruction just presented.
        if (flush_i) begin
            stall_o      = 1'b0;
            state_next   = ST_IDLE;
            counter_next = '0;
            valid_next   = 1'b0;
            cf_next      = 4'd0;
            result_next  = alu_result_o;
            store_next   = store_data_o;
            rd_next      = rd_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            counter_reg    <= '0;
            op_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            acc_reg        <= '0;
            rd_lat_reg     <= '0;
            cf_lat_reg     <= '0;
            store_lat_reg  <= '0;
            valid_o        <= 1'b0;
            alu_result_o   <= '0;
            store_data_o   <= '0;
            control_flow_o <= '0;
            rd_o           <= '0;
        end else begin
            state_reg      <= state_next;
            counter_reg    <= counter_next;
            op_reg         <= op_next;
            a_reg          <= a_next;
            b_reg          <= b_next;
            acc_reg        <= acc_next;
            rd_lat_reg     <= rd_lat_next;
            cf_lat_reg     <= cf_lat_next;
            store_lat_reg  <= store_lat_next;
            valid_o        <= valid_next;
            alu_result_o   <= result_next;
            store_data_o   <= store_next;
            control_flow_o <= cf_next;
            rd_o           <= rd_next;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, mul/div latency and results, flush and reset.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [31:0] rd1_data_i, rd2_data_i, imm_i;
    logic        alu_src_i;
    logic [3:0]  alu_control_i;
    logic [3:0]  control_flow_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        valid_o;
    logic [31:0] alu_result_o, store_data_o;
    logic [3:0]  control_flow_o;
    logic [4:0]  rd_o;
    logic        stall_o;

    int total = 0;
    int bad   = 0;
    int cycles;
    logic seen;

    ex_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_i        (valid_i),
        .rd1_data_i     (rd1_data_i),
        .rd2_data_i     (rd2_data_i),
        .imm_i          (imm_i),
        .alu_src_i      (alu_src_i),
        .alu_control_i  (alu_control_i),
        .control_flow_i (control_flow_i),
        .rd_i           (rd_i),
        .flush_i        (flush_i),
        .valid_o        (valid_o),
        .alu_result_o   (alu_result_o),
        .store_data_o   (store_data_o),
        .control_flow_o (control_flow_o),
        .rd_o           (rd_o),
        .stall_o        (stall_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic [4:0] rd,
                         input logic [3:0] cf);
        valid_i        = 1'b1;
        alu_control_i  = op;
        rd1_data_i     = a;
        rd2_data_i     = b;
        imm_i          = imm;
        alu_src_i      = src;
        rd_i           = rd;
        control_flow_i = cf;
    endtask

    task automatic run_single(input string tag, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp);
        drive(op, a, b, 32'h0, 1'b0, 5'd7, 4'h5);
        #1;
        check({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
        tick();
        valid_i = 1'b0;
        check(tag, alu_result_o, exp);
        check({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        $display("single %s a=%h b=%h result=%h", tag, a, b, alu_result_o);
    endtask

    task automatic run_muldiv(input string tag, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp);
        drive(op, a, b, 32'h0, 1'b0, 5'd9, 4'h3);
        cycles = 0;
        #1;
        while (stall_o && cycles < 100) begin
            cycles++;
            tick();
        end
        check({tag, "_stall_cycles"}, cycles, 32'd33);
        check({tag, "_done_bubble"}, {31'd0, valid_o}, 32'd0);
        tick();
        valid_i = 1'b0;
        check(tag, alu_result_o, exp);
        check({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        check({tag, "_rd"}, {27'd0, rd_o}, 32'd9);
        check({tag, "_cf"}, {28'd0, control_flow_o}, 32'd3);
        $display("muldiv %s a=%h b=%h result=%h stall=%0d", tag, a, b, alu_result_o, cycles);
    endtask

    initial begin
        rst_n = 1'b0;
        valid_i = 1'b0; flush_i = 1'b0; alu_src_i = 1'b0;
        rd1_data_i = '0; rd2_data_i = '0; imm_i = '0;
        alu_control_i = '0; control_flow_i = '0; rd_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", {31'd0, valid_o}, 32'd0);
        check("reset_result", alu_result_o, 32'd0);
        check("reset_cf", {28'd0, control_flow_o}, 32'd0);
        check("reset_stall", {31'd0, stall_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ADD with immediate operand
        drive(4'h0, 32'd5, 32'h0000_0123, 32'hFFFF_FFFD, 1'b1, 5'd3, 4'hA);
        #1;
        check("add_imm_stall", {31'd0, stall_o}, 32'd0);
        tick();
        valid_i = 1'b0;
        check("add_imm", alu_result_o, 32'd2);
        check("add_imm_valid", {31'd0, valid_o}, 32'd1);
        check("add_imm_rd", {27'd0, rd_o}, 32'd3);
        check("add_imm_cf", {28'd0, control_flow_o}, 32'hA);
        check("add_imm_store", store_data_o, 32'h0000_0123);
        $display("single add_imm result=%h", alu_result_o);
        tick();
        check("idle_valid", {31'd0, valid_o}, 32'd0);
        check("idle_cf", {28'd0, control_flow_o}, 32'd0);

        run_single("sra",  4'h7, 32'h8000_0000, 32'd4, 32'hF800_0000);
        run_single("slt",  4'h8, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run_single("sltu", 4'h9, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_single("sub",  4'h1, 32'd3, 32'd5, 32'hFFFF_FFFE);
        run_single("and",  4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        run_single("or",   4'h3, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
        run_single("xor",  4'h4, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
        run_single("sll",  4'h5, 32'd1, 32'd35, 32'd8);
        run_single("srl",  4'h6, 32'h8000_0000, 32'd4, 32'h0800_0000);
        run_single("rsvd", 4'hD, 32'h1234_5678, 32'd9, 32'd0);

        run_muldiv("mul", 4'hA, 32'd7, 32'd6, 32'd42);
        // ADD issued right behind the multiply
        run_single("add_after_mul", 4'h0, 32'd40, 32'd2, 32'd42);
        run_muldiv("mul_wrap", 4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        run_muldiv("divu", 4'hB, 32'd100, 32'd7, 32'd14);
        run_muldiv("remu", 4'hC, 32'd100, 32'd7, 32'd2);
        run_muldiv("divu_zero", 4'hB, 32'd9, 32'd0, 32'hFFFF_FFFF);
        run_muldiv("remu_zero", 4'hC, 32'd9, 32'd0, 32'd9);

        // Flush in the tenth BUSY cycle of a MUL
        drive(4'hA, 32'd7, 32'd6, 32'h0, 1'b0, 5'd9, 4'h3);
        tick();
        repeat (9) tick();
        flush_i = 1'b1;
        #1;
        check("flush_stall_comb", {31'd0, stall_o}, 32'd0);
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("flush_valid", {31'd0, valid_o}, 32'd0);
        check("flush_cf", {28'd0, control_flow_o}, 32'd0);
        check("flush_stall_idle", {31'd0, stall_o}, 32'd0);
        seen = 1'b0;
        repeat (36) begin
            tick();
            if (valid_o) seen = 1'b1;
        end
        check("flush_no_result", {31'd0, seen}, 32'd0);
        $display("flush mul discarded seen_valid=%0d", seen);
        run_single("add_after_flush", 4'h0, 32'd100, 32'd23, 32'd123);

        // Reset in the middle of a DIVU
        drive(4'hB, 32'd100, 32'd7, 32'h0, 1'b0, 5'd9, 4'h3);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, valid_o}, 32'd0);
        check("rst_mid_result", alu_result_o, 32'd0);
        check("rst_mid_rd", {27'd0, rd_o}, 32'd0);
        check("rst_mid_store", store_data_o, 32'd0);
        valid_i = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        run_single("add_after_reset", 4'h0, 32'd10, 32'd20, 32'd30);
        tick();
        check("post_reset_idle_valid", {31'd0, valid_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
